// File: rtl/pixel_writer.sv
// Buffers drawer (X,Y) pixels in a FIFO and issues one framebuffer write per pixel, 2 edges after push;
// writes stall on MEM_BUSY, PIX_READY drops when full. `PIXEL_CLIP_EN drops off-screen pixels at pop.
module pixel_writer #(
  parameter int FIFO_DEPTH = 4,
  parameter int SCREEN_W   = 160,
  parameter int SCREEN_H   = 120,
  parameter int COLOR_W    = 8,
  parameter int ADDR_W     = 15
) (
  input  logic               ACLK,
  input  logic               RST,
  input  logic               EN,
  input  logic [COLOR_W-1:0] COLOR_In,
  input  logic [7:0]         X_In,
  input  logic [7:0]         Y_In,
  input  logic               PIX_VALID,
  output logic               PIX_READY,
  input  logic               FINISH_In,
  input  logic               MEM_BUSY,
  output logic               MEM_WE,
  output logic [ADDR_W-1:0]  MEM_ADDR,
  output logic [COLOR_W-1:0] MEM_DATA,
  output logic               DONE
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [15:0]        fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [COLOR_W-1:0] color;

  logic              full;
  logic              empty;
  logic              busy_state;
  logic              push;
  logic              pop;
  logic              flush;
  logic              wr_ok;
  logic [7:0]        head_x;
  logic [7:0]        head_y;
  logic [ADDR_W-1:0] head_addr;

  assign full       = (count == CNT_W'(FIFO_DEPTH));
  assign empty      = (count == '0);
  assign busy_state = (state == S_RUN) || (state == S_DRAIN);

  assign PIX_READY = (state == S_RUN) && !full;
  assign DONE      = (state == S_DONE);

  // Starting a primitive and aborting one both discard anything buffered.
  assign flush = ((state == S_IDLE) && EN) || (busy_state && !EN);
  assign push  = PIX_VALID && PIX_READY;
  assign pop   = busy_state && EN && !empty && !MEM_BUSY;

  assign {head_x, head_y} = fifo_mem[rd_ptr];
  assign head_addr = ADDR_W'(head_y) * ADDR_W'(SCREEN_W) + ADDR_W'(head_x);

`ifdef PIXEL_CLIP_EN
  assign wr_ok = (int'(head_x) < SCREEN_W) && (int'(head_y) < SCREEN_H);
`else
  assign wr_ok = 1'b1;
`endif

  always_ff @(posedge ACLK) begin
    if (RST) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (EN) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (!EN)           state_nxt = S_IDLE;
        else if (FINISH_In) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        // An empty FIFO here means the last pop already launched its write strobe.
        if (!EN)        state_nxt = S_IDLE;
        else if (empty) state_nxt = S_DONE;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (push && !flush) begin
      fifo_mem[wr_ptr] <= {X_In, Y_In};
    end
  end

  always_ff @(posedge ACLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge ACLK) begin
    if (RST) begin
      color    <= '0;
      MEM_WE   <= 1'b0;
      MEM_ADDR <= '0;
      MEM_DATA <= '0;
    end else begin
      if ((state == S_IDLE) && EN) begin
        color <= COLOR_In;
      end
      MEM_WE <= pop && wr_ok;
      if (pop && wr_ok) begin
        MEM_ADDR <= head_addr;
        MEM_DATA <= color;
      end
    end
  end

endmodule

// File: tb/tb_pixel_writer.sv
// Scoreboard bench for pixel_writer: expected writes are queued at push time and checked when MEM_WE fires.
module tb_pixel_writer;

  logic        ACLK = 1'b0;
  logic        RST = 1'b1;
  logic        EN = 1'b0;
  logic [7:0]  COLOR_In = '0;
  logic [7:0]  X_In = '0;
  logic [7:0]  Y_In = '0;
  logic        PIX_VALID = 1'b0;
  logic        PIX_READY;
  logic        FINISH_In = 1'b0;
  logic        MEM_BUSY = 1'b0;
  logic        MEM_WE;
  logic [14:0] MEM_ADDR;
  logic [7:0]  MEM_DATA;
  logic        DONE;

  typedef struct {
    logic [14:0] addr;
    logic [7:0]  data;
    int          cyc;
  } exp_t;

  exp_t       sb[$];
  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;
  int         last_we_cyc = -1;
  logic [7:0] cur_color;

  pixel_writer dut (
    .ACLK(ACLK), .RST(RST), .EN(EN), .COLOR_In(COLOR_In),
    .X_In(X_In), .Y_In(Y_In), .PIX_VALID(PIX_VALID), .PIX_READY(PIX_READY),
    .FINISH_In(FINISH_In), .MEM_BUSY(MEM_BUSY), .MEM_WE(MEM_WE),
    .MEM_ADDR(MEM_ADDR), .MEM_DATA(MEM_DATA), .DONE(DONE)
  );

  always #5 ACLK = ~ACLK;

  always @(posedge ACLK) cyc <= cyc + 1;

  always @(negedge ACLK) begin
    if (!RST && MEM_WE) begin
      exp_t e;
      vectors++;
      last_we_cyc = cyc;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_write: got addr=%0d data=%h, expected no write", MEM_ADDR, MEM_DATA);
      end else begin
        e = sb.pop_front();
        if (MEM_ADDR !== e.addr || MEM_DATA !== e.data || (e.cyc >= 0 && cyc != e.cyc)) begin
          miscompares++;
          $display("FAIL write: got addr=%0d data=%h cyc=%0d, expected addr=%0d data=%h cyc=%0d",
                   MEM_ADDR, MEM_DATA, cyc, e.addr, e.data, e.cyc);
        end
      end
    end
  end

  function automatic bit will_write(input int x, input int y);
`ifdef PIXEL_CLIP_EN
    return (x < 160) && (y < 120);
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [14:0] model_addr(input int x, input int y);
    int a;
    a = (y * 160 + x) % 32768;
    return a[14:0];
  endfunction

  // Called at the #1-after-posedge phase; returns at the same phase after the push edge.
  task automatic push_pix(input int x, input int y, input bit timed, input bit track);
    int   waited;
    exp_t e;
    waited = 0;
    X_In = x[7:0];
    Y_In = y[7:0];
    PIX_VALID = 1'b1;
    while (!PIX_READY && waited < 50) begin
      @(posedge ACLK); #1;
      waited++;
    end
    if (!PIX_READY) begin
      vectors++;
      miscompares++;
      $display("FAIL push_timeout: got PIX_READY=0 for (%0d,%0d), expected 1 within 50 cycles", x, y);
      PIX_VALID = 1'b0;
      return;
    end
    if (track && will_write(x, y)) begin
      e.addr = model_addr(x, y);
      e.data = cur_color;
      e.cyc  = timed ? cyc + 2 : -1;
      sb.push_back(e);
    end
    @(posedge ACLK); #1;
    PIX_VALID = 1'b0;
  endtask

  task automatic start_prim(input logic [7:0] col);
    EN = 1'b1;
    COLOR_In = col;
    cur_color = col;
    @(posedge ACLK); #1;
    vectors++;
    if (PIX_READY !== 1'b1) begin
      miscompares++;
      $display("FAIL start_ready: got %b, expected 1", PIX_READY);
    end
  endtask

  task automatic finish_wait(input bit exact);
    bit seen;
    seen = 1'b0;
    FINISH_In = 1'b1;
    @(posedge ACLK); #1;
    FINISH_In = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge ACLK);
      if (DONE) seen = 1'b1;
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL done_timeout: got DONE=0, expected a pulse within 60 cycles");
    end else begin
      vectors++;
      if (sb.size() != 0) begin
        miscompares++;
        $display("FAIL done_early: got %0d writes pending, expected 0", sb.size());
      end
      vectors++;
      if (exact ? (cyc != last_we_cyc + 1) : (cyc <= last_we_cyc)) begin
        miscompares++;
        $display("FAIL done_timing: got DONE cycle %0d, expected %s%0d", cyc, exact ? "" : "> ",
                 exact ? last_we_cyc + 1 : last_we_cyc);
      end
    end
    EN = 1'b0;
    @(posedge ACLK); #1;
    vectors++;
    if (DONE !== 1'b0) begin
      miscompares++;
      $display("FAIL done_width: got DONE=%b, expected 0 one cycle later", DONE);
    end
  endtask

  task automatic test_reset;
    RST = 1'b1;
    repeat (2) @(posedge ACLK);
    #1 RST = 1'b0;
    PIX_VALID = 1'b1;
    repeat (3) @(posedge ACLK);
    #1;
    PIX_VALID = 1'b0;
    vectors++;
    if (PIX_READY !== 1'b0) begin miscompares++; $display("FAIL rst_ready: got %b, expected 0", PIX_READY); end
    vectors++;
    if (MEM_WE !== 1'b0) begin miscompares++; $display("FAIL rst_we: got %b, expected 0", MEM_WE); end
    vectors++;
    if (MEM_ADDR !== 15'd0) begin miscompares++; $display("FAIL rst_addr: got %0d, expected 0", MEM_ADDR); end
    vectors++;
    if (MEM_DATA !== 8'd0) begin miscompares++; $display("FAIL rst_data: got %h, expected 00", MEM_DATA); end
    vectors++;
    if (DONE !== 1'b0) begin miscompares++; $display("FAIL rst_done: got %b, expected 0", DONE); end
  endtask

  task automatic test_single_pixel;
    start_prim(8'h3C);
    push_pix(5, 2, 1'b1, 1'b1);
    finish_wait(1'b1);
    vectors++;
    if (MEM_ADDR !== 15'd325) begin miscompares++; $display("FAIL single_addr: got %0d, expected 325", MEM_ADDR); end
  endtask

  task automatic test_backpressure;
    int   idx;
    exp_t e;
    start_prim(8'hA5);
    MEM_BUSY = 1'b1;
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      X_In = 8'(10 + idx);
      Y_In = 8'(3 + idx);
      PIX_VALID = 1'b1;
      if (PIX_READY && idx < 6) begin
        e.addr = model_addr(10 + idx, 3 + idx);
        e.data = cur_color;
        e.cyc  = -1;
        sb.push_back(e);
        idx++;
      end
      @(posedge ACLK); #1;
    end
    PIX_VALID = 1'b0;
    vectors++;
    if (idx != 4) begin miscompares++; $display("FAIL bp_accepted: got %0d, expected 4", idx); end
    vectors++;
    if (PIX_READY !== 1'b0) begin miscompares++; $display("FAIL bp_ready: got %b, expected 0", PIX_READY); end
    vectors++;
    if (MEM_ADDR !== 15'd325 || MEM_DATA !== 8'h3C) begin
      miscompares++;
      $display("FAIL bp_hold: got addr=%0d data=%h, expected 325/3c", MEM_ADDR, MEM_DATA);
    end
    MEM_BUSY = 1'b0;
    push_pix(14, 7, 1'b0, 1'b1);
    push_pix(15, 8, 1'b0, 1'b1);
    finish_wait(1'b0);
  endtask

  task automatic test_back_to_back;
    start_prim(8'h55);
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (PIX_READY !== 1'b1) begin miscompares++; $display("FAIL stream_ready: got 0 at pixel %0d, expected 1", i); end
      push_pix(i, i, 1'b1, 1'b1);
    end
    finish_wait(1'b1);
  endtask

  task automatic test_abort;
    bit done_seen;
    done_seen = 1'b0;
    start_prim(8'h77);
    MEM_BUSY = 1'b1;
    for (int i = 0; i < 3; i++) push_pix(20 + i, 1, 1'b0, 1'b0);
    EN = 1'b0;
    @(posedge ACLK); #1;
    MEM_BUSY = 1'b0;
    vectors++;
    if (PIX_READY !== 1'b0) begin miscompares++; $display("FAIL abort_ready: got %b, expected 0", PIX_READY); end
    for (int i = 0; i < 10; i++) begin
      @(posedge ACLK); #1;
      if (DONE) done_seen = 1'b1;
    end
    vectors++;
    if (done_seen) begin miscompares++; $display("FAIL abort_done: got DONE pulse, expected none"); end
    start_prim(8'h11);
    finish_wait(1'b0);
  endtask

  task automatic test_clip;
    start_prim(8'h99);
    push_pix(159, 119, 1'b0, 1'b1);
    push_pix(160, 0, 1'b0, 1'b1);
    push_pix(0, 120, 1'b0, 1'b1);
    finish_wait(1'b0);
    vectors++;
`ifdef PIXEL_CLIP_EN
    if (MEM_ADDR !== 15'd19199) begin miscompares++; $display("FAIL clip_last: got %0d, expected 19199", MEM_ADDR); end
`else
    if (MEM_ADDR !== 15'd19200) begin miscompares++; $display("FAIL clip_last: got %0d, expected 19200", MEM_ADDR); end
`endif
  endtask

  initial begin
    test_reset();
    test_single_pixel();
    test_backpressure();
    test_back_to_back();
    test_abort();
    test_clip();
    repeat (4) @(posedge ACLK);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL leftover: got %0d writes never issued, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/pixel_writer.md
# pixel_writer

Consumer end of the rasteriser pixel stream: accepts the `(X, Y)` coordinates emitted by the triangle/line drawing units, buffers them in a small FIFO, and turns each one into a single-cycle write on the framebuffer memory port. The write port is shared with the VGA scan-out path, so writes stall while memory is busy. The block reports completion once the drawer signals finish and every buffered pixel has been written.

## Interface
- `FIFO_DEPTH`, 4: pixel buffer entries; power of two, at least 2.
- `SCREEN_W`, 160: framebuffer width in pixels.
- `SCREEN_H`, 120: framebuffer height in pixels.
- `COLOR_W`, 8: colour word width.
- `ADDR_W`, 15: framebuffer address width.

- `ACLK` in 1: clock; all logic is on the rising edge.
- `RST` in 1: synchronous, active-high reset.
- `EN` in 1: high starts a primitive from IDLE; low in RUN/DRAIN aborts.
- `COLOR_In` in COLOR_W: primitive colour, latched on the start edge.
- `X_In` in 8: pixel column from the drawer.
- `Y_In` in 8: pixel row from the drawer.
- `PIX_VALID` in 1: `X_In`/`Y_In` are valid this cycle.
- `PIX_READY` out 1: the block can accept a pixel this cycle.
- `FINISH_In` in 1: drawer has emitted its last pixel (level or pulse).
- `MEM_BUSY` in 1: framebuffer port is held by scan-out; no write may be issued.
- `MEM_WE` out 1: one-cycle write strobe.
- `MEM_ADDR` out ADDR_W: write address, `Y*SCREEN_W + X`.
- `MEM_DATA` out COLOR_W: write data (the latched colour).
- `DONE` out 1: one-cycle pulse when the primitive is fully written.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE → RUN when `EN`=1. On that edge: latch `COLOR_In` and clear the FIFO.
- RUN → DRAIN when `FINISH_In`=1 is sampled. A pixel presented on the same edge is still accepted.
- DRAIN → DONE when the FIFO is empty and no write is outstanding.
- DONE → IDLE unconditionally after 1 cycle. `DONE`=1 only while in the DONE state.
- Abort: `EN`=0 in RUN or DRAIN → IDLE next edge. The FIFO is flushed, no further `MEM_WE` is issued, and `DONE` is not pulsed.
- Push: `PIX_VALID && PIX_READY` at an edge writes `{X_In, Y_In}` into the FIFO.
- `PIX_READY` = (state is RUN) && !full. It is derived from the registered count only, with no combinational path from `MEM_BUSY`.
- `PIX_VALID` is ignored when `PIX_READY`=0. No pixel is accepted in IDLE, DRAIN or DONE.
- Pop: when the FIFO is non-empty, `MEM_BUSY`=0 and state is RUN or DRAIN:
  - pop the head entry;
  - register `MEM_ADDR` = `Y*SCREEN_W + X`, truncated to ADDR_W;
  - register `MEM_DATA` = latched colour;
  - assert `MEM_WE`=1 for the following cycle.
- Push and pop on the same edge leave the count unchanged. A push when full cannot occur, because READY is low.
- The count runs 0..FIFO_DEPTH; read and write pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset values: state IDLE, FIFO empty, `PIX_READY`=0, `MEM_WE`=0, `MEM_ADDR`=0, `MEM_DATA`=0, `DONE`=0.
- `RST` has priority over every other input. Reset mid-primitive discards all buffered pixels.
- Latency: a pixel accepted at edge k with the FIFO empty and `MEM_BUSY`=0 at edge k+1 produces `MEM_WE`=1 in the cycle following edge k+1.
- Throughput: 1 pixel/cycle sustained while `MEM_BUSY`=0.
- `MEM_BUSY`=1 blocks the pop at that edge. `MEM_ADDR` and `MEM_DATA` hold their last values, and `MEM_WE` drops to 0.
- `DONE` is asserted no earlier than the cycle after the final `MEM_WE` cycle.

## Configuration
- `PIXEL_CLIP_EN` defined:
  - a pixel with `X >= SCREEN_W` or `Y >= SCREEN_H` is still accepted (READY handshake unchanged);
  - it is discarded at pop, with no `MEM_WE`;
  - it still consumes one pop cycle.
- `PIXEL_CLIP_EN` undefined: no range check. Every pixel is written, and the address wraps modulo 2^ADDR_W.

## Test plan
- Reset then idle: `RST`=1 for 2 cycles, then `EN`=0 → all outputs 0, `PIX_READY`=0, no `MEM_WE`.
- Single pixel: start with colour 0x3C, push (5,2), then `FINISH_In` → `MEM_WE` once with `MEM_ADDR`=325 and `MEM_DATA`=0x3C. `DONE` pulses 1 cycle after that write.
- Backpressure: `MEM_BUSY`=1 while pushing 6 pixels with FIFO_DEPTH=4 → exactly 4 accepted and `PIX_READY`=0. Releasing busy gives 4 writes in push order, then the remaining 2 are accepted.
- Triangle stream: pixels (0,0)…(5,5) at 1/cycle with `MEM_BUSY`=0 → one write per pixel, each 2 edges after its push, in order. `DONE` after the last write.
- Abort: `EN`=0 with 3 pixels buffered → IDLE next edge, no further `MEM_WE`, no `DONE`.
- Clip (with `PIXEL_CLIP_EN`): push (159,119), (160,0), (0,120) → one write at address 19199; the other two are dropped. Without the macro: three writes.
